// File: rtl/traffic_light_sequencer.sv
// Intersection master FSM: sequences main/side/walk lamps,
// selects the timing interval and counts it down on a 1 Hz enable.
module traffic_light_sequencer #(
    parameter int VALUE_W = 4
) (
    input  logic               clk,
    input  logic               Sync_Reset,
    input  logic               Sync_Reprogram,
    input  logic               Sensor,
    input  logic               Walk_Request,
    input  logic               Tick_1Hz,
    input  logic [VALUE_W-1:0] Value,
    output logic [1:0]         Interval,
    output logic [2:0]         Main_Light,
    output logic [2:0]         Side_Light,
    output logic               Walk_Light,
    output logic [2:0]         State
);

    typedef enum logic [2:0] {
        MG     = 3'd0,
        MG_EXT = 3'd1,
        MY     = 3'd2,
        WALK   = 3'd3,
        SG     = 3'd4,
        SG_EXT = 3'd5,
        SY     = 3'd6
    } state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    state_t             state_q, state_d;
    logic [VALUE_W-1:0] count_q, count_d;
    logic               load_q, load_d;
    logic               pend_q, pend_d;
    logic [1:0]         int_d;
    logic [2:0]         main_d, side_d;
    logic               walk_d;
    logic               restart;

    assign restart = Sync_Reset | Sync_Reprogram;
    assign State   = state_q;

    // Next state, timer, walk latch and lamp decode of the next state
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        load_d  = load_q;
        pend_d  = pend_q | Walk_Request;
        if (restart) begin
            state_d = MG;
            count_d = '0;
            load_d  = 1'b1;
            pend_d  = 1'b0;
        end else if (load_q) begin
            count_d = (Value == '0) ? VALUE_W'(1) : Value;
            load_d  = 1'b0;
        end else if (Tick_1Hz) begin
            if (count_q <= VALUE_W'(1)) begin
                load_d = 1'b1;
                unique case (state_q)
                    MG:      state_d = Sensor ? MY : MG_EXT;
                    MG_EXT:  state_d = MY;
                    MY:      state_d = pend_q ? WALK : SG;
                    WALK:    state_d = SG;
                    SG:      state_d = Sensor ? SG_EXT : SY;
                    SG_EXT:  state_d = SY;
                    SY:      state_d = MG;
                    default: state_d = MG;
                endcase
            end else begin
                count_d = count_q - VALUE_W'(1);
            end
        end
        // Entering WALK serves the old request; a fresh one re-latches
        if (!restart && state_d == WALK && state_q != WALK)
            pend_d = Walk_Request;

        int_d  = 2'b00;
        main_d = RED;
        side_d = RED;
        walk_d = 1'b0;
        unique case (state_d)
            MG:      main_d = GRN;
            MG_EXT:  begin int_d = 2'b01; main_d = GRN; end
            MY:      begin int_d = 2'b10; main_d = YEL; end
            WALK:    begin int_d = 2'b01; walk_d = 1'b1; end
            SG:      side_d = GRN;
            SG_EXT:  begin int_d = 2'b01; side_d = GRN; end
            SY:      begin int_d = 2'b10; side_d = YEL; end
            default: main_d = GRN;
        endcase
    end

    // State, timer and registered lamp outputs
    always_ff @(posedge clk) begin
        if (Sync_Reset) begin
            state_q    <= MG;
            count_q    <= '0;
            load_q     <= 1'b1;
            pend_q     <= 1'b0;
            Interval   <= 2'b00;
            Main_Light <= GRN;
            Side_Light <= RED;
            Walk_Light <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            load_q     <= load_d;
            pend_q     <= pend_d;
            Interval   <= int_d;
            Main_Light <= main_d;
            Side_Light <= side_d;
            Walk_Light <= walk_d;
        end
    end

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Directed bench for traffic_light_sequencer: measures each state's
// duration in ticks against a stub parameter store.
module tb_traffic_light_sequencer;

    logic       clk = 1'b0;
    logic       Sync_Reset = 1'b1;
    logic       Sync_Reprogram = 1'b0;
    logic       Sensor = 1'b1;
    logic       Walk_Request = 1'b0;
    logic       Tick_1Hz = 1'b0;
    logic [3:0] Value;
    logic [1:0] Interval;
    logic [2:0] Main_Light;
    logic [2:0] Side_Light;
    logic       Walk_Light;
    logic [2:0] State;

    logic [3:0] base = 4'd6;
    logic [3:0] ext  = 4'd3;
    logic [3:0] yel  = 4'd2;
    int tick_period = 1;
    int tcnt = 0;
    int n_chk = 0;
    int n_fail = 0;
    int mc;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    traffic_light_sequencer #(.VALUE_W(4)) dut (
        .clk(clk),
        .Sync_Reset(Sync_Reset),
        .Sync_Reprogram(Sync_Reprogram),
        .Sensor(Sensor),
        .Walk_Request(Walk_Request),
        .Tick_1Hz(Tick_1Hz),
        .Value(Value),
        .Interval(Interval),
        .Main_Light(Main_Light),
        .Side_Light(Side_Light),
        .Walk_Light(Walk_Light),
        .State(State)
    );

    always #5 clk = ~clk;

    assign Value = (Interval == 2'b00) ? base :
                   (Interval == 2'b01) ? ext : yel;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; inputs change 1 ns after the edge, lamps checked there
    task automatic cyc();
        logic ok;
        @(posedge clk);
        #1;
        tcnt = (tcnt >= tick_period - 1) ? 0 : tcnt + 1;
        Tick_1Hz = (tcnt == 0);
        ok = $onehot(Main_Light) && $onehot(Side_Light)
             && (Main_Light == R || Side_Light == R);
        check("lamp_inv", int'(ok), 1);
    endtask

    task automatic outs(input string tag, input int es, input int ei,
                        input int em, input int esd, input int ew);
        check({tag, " state"}, State, es);
        check({tag, " intv"}, Interval, ei);
        check({tag, " main"}, Main_Light, em);
        check({tag, " side"}, Side_Light, esd);
        check({tag, " walk"}, Walk_Light, ew);
    endtask

    // Called right after entry; next edge is the LOAD edge
    task automatic run_state(input string tag, input int es, input int et,
                             input int ei, input int em, input int esd,
                             input int ew, input int walk_at,
                             output int cycles);
        int  ticks;
        bit  first;
        outs(tag, es, ei, em, esd, ew);
        ticks = 0;
        cycles = 0;
        first = 1'b1;
        while (State == 3'(es) && cycles < 300) begin
            Walk_Request = (cycles == walk_at);
            if (Tick_1Hz && !first) ticks++;
            first = 1'b0;
            cyc();
            cycles++;
        end
        Walk_Request = 1'b0;
        check({tag, " bound"}, int'(cycles < 300), 1);
        check({tag, " ticks"}, ticks, et);
    endtask

    initial begin
        repeat (2) cyc();
        outs("reset", 0, 0, G, R, 0);
        Sync_Reset = 1'b0;

        // Sensor=1, tick every cycle
        run_state("t1 MG", 0, 6, 0, G, R, 0, -1, mc);
        check("t1 MG cycles", mc, 7);
        run_state("t1 MY", 2, 2, 2, Y, R, 0, -1, mc);
        run_state("t1 SG", 4, 6, 0, R, G, 0, -1, mc);
        run_state("t1 SGX", 5, 3, 1, R, G, 0, -1, mc);
        run_state("t1 SY", 6, 2, 2, R, Y, 0, -1, mc);

        // Sensor=0
        Sensor = 1'b0;
        run_state("t2 MG", 0, 6, 0, G, R, 0, -1, mc);
        run_state("t2 MGX", 1, 3, 1, G, R, 0, -1, mc);
        run_state("t2 MY", 2, 2, 2, Y, R, 0, -1, mc);
        run_state("t2 SG", 4, 6, 0, R, G, 0, -1, mc);
        run_state("t2 SY", 6, 2, 2, R, Y, 0, -1, mc);

        // One-cycle walk request served once
        run_state("t3 MG", 0, 6, 0, G, R, 0, 2, mc);
        run_state("t3 MGX", 1, 3, 1, G, R, 0, -1, mc);
        run_state("t3 MY", 2, 2, 2, Y, R, 0, -1, mc);
        run_state("t3 WALK", 3, 3, 1, R, R, 1, -1, mc);
        run_state("t3 SG", 4, 6, 0, R, G, 0, -1, mc);
        run_state("t3 SY", 6, 2, 2, R, Y, 0, -1, mc);
        run_state("t3 MG2", 0, 6, 0, G, R, 0, -1, mc);
        run_state("t3 MGX2", 1, 3, 1, G, R, 0, -1, mc);
        run_state("t3 MY2", 2, 2, 2, Y, R, 0, -1, mc);

        // Reprogram mid SG_EXT drops a pending walk
        Sensor = 1'b1;
        run_state("t4 SG", 4, 6, 0, R, G, 0, 1, mc);
        outs("t4 SGX", 5, 1, R, G, 0);
        cyc();
        cyc();
        Sync_Reprogram = 1'b1;
        cyc();
        outs("t4 rp1", 0, 0, G, R, 0);
        cyc();
        check("t4 rp2 state", State, 0);
        cyc();
        check("t4 rp3 state", State, 0);
        Sync_Reprogram = 1'b0;
        run_state("t4 MG", 0, 6, 0, G, R, 0, -1, mc);
        run_state("t4 MY", 2, 2, 2, Y, R, 0, -1, mc);

        // Yellow value 0 acts as 1; reset mid MY
        yel = 4'd0;
        run_state("t5 SG", 4, 6, 0, R, G, 0, -1, mc);
        run_state("t5 SGX", 5, 3, 1, R, G, 0, -1, mc);
        run_state("t5 SY", 6, 1, 2, R, Y, 0, -1, mc);
        run_state("t5 MG", 0, 6, 0, G, R, 0, -1, mc);
        outs("t5 MY", 2, 2, Y, R, 0);
        Sync_Reset = 1'b1;
        cyc();
        outs("t5 rst", 0, 0, G, R, 0);

        // Slow tick, one tick landing in the LOAD cycle
        yel = 4'd2;
        tick_period = 10;
        cyc();
        Sync_Reset = 1'b0;
        tcnt = 0;
        Tick_1Hz = 1'b1;
        run_state("t6 MG", 0, 6, 0, G, R, 0, -1, mc);
        check("t6 MG cycles", mc, 61);
        run_state("t6 MY", 2, 2, 2, Y, R, 0, -1, mc);
        check("t6 MY cycles", mc, 20);
        outs("t6 SG", 4, 0, R, G, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_light_sequencer.md
Name: traffic_light_sequencer

Overview:
- Master FSM for the intersection controller: sequences main/side/walk lamps and drives the `Interval` select of the timing-parameter store.
- Reads back the selected duration on `Value` and counts it down on a 1 Hz enable.
- Sits between the input synchronisers (Sensor, Walk_Request, Sync_Reprogram) and the lamp drivers.

Parameters:
- VALUE_W, 4, width of the `Value` duration input and of the internal countdown counter.

Ports:
- clk  in  1  system clock
- Sync_Reset  in  1  synchronous, active-high reset
- Sync_Reprogram  in  1  synchronous restart after a parameter reprogram
- Sensor  in  1  side-street vehicle present (pre-synchronised)
- Walk_Request  in  1  pedestrian request (pre-synchronised, any length)
- Tick_1Hz  in  1  one-cycle enable, 1 Hz
- Value  in  VALUE_W  duration in ticks for the current `Interval` (combinational from the parameter store)
- Interval  out  2  00 = base, 01 = extended, 10 = yellow (11 is never driven)
- Main_Light  out  3  {R,Y,G}, one-hot
- Side_Light  out  3  {R,Y,G}, one-hot
- Walk_Light  out  1  walk lamp
- State  out  3  encoded state, for debug and the bench

Behaviour:
- Clocking: one clock; reset is synchronous and active-high. All outputs are registered.
- Priority: Sync_Reset > Sync_Reprogram > normal operation.
- States (encoding / Interval / Main / Side / Walk):
  - MG 0 / 00 / G / R / 0
  - MG_EXT 1 / 01 / G / R / 0
  - MY 2 / 10 / Y / R / 0
  - WALK 3 / 01 / R / R / 1
  - SG 4 / 00 / R / G / 0
  - SG_EXT 5 / 01 / R / G / 0
  - SY 6 / 10 / R / Y / 0
- Transitions, taken on expiry:
  - MG: Sensor=1 → MY; Sensor=0 → MG_EXT
  - MG_EXT → MY
  - MY: walk_pend=1 → WALK; else → SG
  - WALK → SG
  - SG: Sensor=1 → SG_EXT; Sensor=0 → SY
  - SG_EXT → SY
  - SY → MG
  - Sensor is sampled in the expiry cycle only.
- Reset / reprogram:
  - Either one forces State=MG, Interval=00, Main=001, Side=100, Walk_Light=0, walk_pend=0, count=0, load=1.
  - While held, the block stays in that state and does not count.
- Timer:
  - The cycle after any state entry, or after reset/reprogram deassert, is the LOAD cycle: count ← Value.
  - A Tick_1Hz in the LOAD cycle is ignored.
  - After LOAD, each tick decrements count.
  - Expiry = tick while count==1; the state changes at that edge and the next cycle is LOAD.
  - A state therefore lasts exactly Value ticks.
  - Value=0 is treated as 1.
  - There is no wrap-around: count never decrements below 1 without expiring.
- Walk latch:
  - walk_pend is set by Walk_Request=1 in any state except during reset/reprogram.
  - walk_pend is cleared on the edge entering WALK.
  - A request during WALK re-sets it; it is then served on the next MY.
  - Set and clear in the same cycle: the clear wins only for a request that was already pending. A request arriving in the entry cycle re-latches.
- Interval changes only on state transitions, together with the lamps; no lamp glitches are permitted.
- The one-hot lamp invariant must hold every cycle. Main and Side must never both be non-red.

Test Plan:
- Sensor=1, no walk, Tick_1Hz=1 every cycle, stub base=6/ext=3/yel=2 → MG 6 ticks, MY 2, SG 6, SG_EXT 3, SY 2, back to MG; Interval sequence 00,10,00,01,10,00.
- Sensor=0, same stub → MG 6, MG_EXT 3, MY 2, SG 6, SY 2.
- 1-cycle Walk_Request during MG → after MY, WALK for 3 ticks with Main=Side=100 and Walk_Light=1, then SG; a second cycle gives no WALK.
- Sync_Reprogram pulse mid-SG_EXT, held 3 cycles → next edge State=0, Interval=00, Main=001; MG then lasts a full 6 ticks after release; pending walk is dropped.
- Stub Value=0 for yellow → MY and SY last 1 tick each; a Sync_Reset pulse mid-MY → MG and all reset values on the next edge.
- Tick every 10 cycles, including one tick aligned with a LOAD cycle → durations are counted in ticks, not cycles; the LOAD-cycle tick adds no decrement.
